// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/MEM arbiter for the shared single-port memory
// Data port has priority; a starvation counter forces a fetch grant after STARVE_MAX data wins.
module mem_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clock_me,
    input  logic        resetn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ready,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        dm_err,
    output logic [31:0] mem_pc,
    output logic [31:0] mem_in,
    output logic        mem_wmem,
    input  logic [31:0] mem_out,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam logic [7:0] SMAX   = 8'(STARVE_MAX);
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic        r_win_dm;
    logic [3:0]  r_cnt;
    logic [7:0]  r_starve;
    logic [31:0] r_if_rdata;
    logic        r_if_err;
    logic [31:0] r_dm_rdata;
    logic        r_dm_err;

    logic        w_accept_ok;
    logic        w_force_if;
    logic        w_pick_if;
    logic        w_pick_dm;
    logic        w_grant;
    logic [31:0] w_sel_addr;
    logic        w_last;

    assign w_accept_ok = (r_state == S_IDLE) || (r_state == S_RESP);
    assign w_force_if  = (SMAX != 8'd0) && (r_starve == SMAX);
    assign w_pick_if   = if_req && (!dm_req || w_force_if);
    assign w_pick_dm   = dm_req && !w_pick_if;
    assign w_grant     = w_accept_ok && (w_pick_if || w_pick_dm);
    assign w_sel_addr  = w_pick_if ? if_addr : dm_addr;
    assign w_last      = (r_state == S_ACCESS) && (r_cnt == 4'd0);

    always_ff @(posedge clock_me or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_we       <= 1'b0;
            r_win_dm   <= 1'b0;
            r_cnt      <= 4'd0;
            r_starve   <= 8'd0;
            r_if_rdata <= 32'd0;
            r_if_err   <= 1'b0;
            r_dm_rdata <= 32'd0;
            r_dm_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_grant) begin
                        r_addr   <= w_sel_addr;
                        r_we     <= w_pick_dm && dm_we;
                        r_wdata  <= w_pick_dm ? dm_wdata : 32'd0;
                        r_win_dm <= w_pick_dm;
                        // Count data wins only while fetch is actually waiting
                        if (w_pick_dm && if_req) begin
                            if (r_starve != SMAX)
                                r_starve <= r_starve + 8'd1;
                        end else begin
                            r_starve <= 8'd0;
                        end
                        if (w_sel_addr[1:0] != 2'b00) begin
                            r_state <= S_RESP;
                            if (w_pick_dm) begin
                                r_dm_rdata <= 32'd0;
                                r_dm_err   <= 1'b1;
                            end else begin
                                r_if_rdata <= 32'd0;
                                r_if_err   <= 1'b1;
                            end
                        end else begin
                            r_state <= S_ACCESS;
                            r_cnt   <= LAT_M1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                        if (r_win_dm) begin
                            r_dm_rdata <= r_we ? 32'd0 : mem_out;
                            r_dm_err   <= 1'b0;
                        end else begin
                            r_if_rdata <= mem_out;
                            r_if_err   <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign if_ready  = w_accept_ok && w_pick_if;
    assign dm_ready  = w_accept_ok && w_pick_dm;
    assign if_rvalid = (r_state == S_RESP) && !r_win_dm;
    assign dm_rvalid = (r_state == S_RESP) && r_win_dm;
    assign if_rdata  = r_if_rdata;
    assign if_err    = r_if_err;
    assign dm_rdata  = r_dm_rdata;
    assign dm_err    = r_dm_err;
    assign busy      = (r_state == S_ACCESS);
    assign mem_pc    = busy ? r_addr : 32'd0;
    assign mem_in    = busy ? r_wdata : 32'd0;
    assign mem_wmem  = w_last && r_we;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
// u_a: MEM_LAT=1, STARVE_MAX=4; u_b: MEM_LAT=3, STARVE_MAX=0 (shared stimulus).
module tb_mem_arbiter;
    typedef struct packed {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [31:0] mem_out;
    } ins_t;

    typedef struct packed {
        logic        if_ready;
        logic        dm_ready;
        logic        if_rvalid;
        logic [31:0] if_rdata;
        logic        if_err;
        logic        dm_rvalid;
        logic [31:0] dm_rdata;
        logic        dm_err;
        logic [31:0] mem_pc;
        logic [31:0] mem_in;
        logic        mem_wmem;
        logic        busy;
    } outs_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_out;

    logic        a_if_ready, a_if_rvalid, a_if_err, a_dm_ready, a_dm_rvalid, a_dm_err, a_mem_wmem, a_busy;
    logic [31:0] a_if_rdata, a_dm_rdata, a_mem_pc, a_mem_in;
    logic        b_if_ready, b_if_rvalid, b_if_err, b_dm_ready, b_dm_rvalid, b_dm_err, b_mem_wmem, b_busy;
    logic [31:0] b_if_rdata, b_dm_rdata, b_mem_pc, b_mem_in;

    outs_t oa, ob;
    assign oa = {a_if_ready, a_dm_ready, a_if_rvalid, a_if_rdata, a_if_err, a_dm_rvalid,
                 a_dm_rdata, a_dm_err, a_mem_pc, a_mem_in, a_mem_wmem, a_busy};
    assign ob = {b_if_ready, b_dm_ready, b_if_rvalid, b_if_rdata, b_if_err, b_dm_rvalid,
                 b_dm_rdata, b_dm_err, b_mem_pc, b_mem_in, b_mem_wmem, b_busy};

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_a (
        .clock_me(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_ready(a_if_ready), .if_rvalid(a_if_rvalid),
        .if_rdata(a_if_rdata), .if_err(a_if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(a_dm_ready), .dm_rvalid(a_dm_rvalid), .dm_rdata(a_dm_rdata), .dm_err(a_dm_err),
        .mem_pc(a_mem_pc), .mem_in(a_mem_in), .mem_wmem(a_mem_wmem), .mem_out(mem_out),
        .busy(a_busy)
    );

    mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(0)) u_b (
        .clock_me(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_ready(b_if_ready), .if_rvalid(b_if_rvalid),
        .if_rdata(b_if_rdata), .if_err(b_if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(b_dm_ready), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata), .dm_err(b_dm_err),
        .mem_pc(b_mem_pc), .mem_in(b_mem_in), .mem_wmem(b_mem_wmem), .mem_out(mem_out),
        .busy(b_busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic zero_inputs();
        if_req = 1'b0; if_addr = 32'd0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = 32'd0; dm_wdata = 32'd0; mem_out = 32'd0;
    endtask

    task automatic do_reset();
        zero_inputs();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    localparam logic [31:0] IR = 32'h8C010004;
    localparam logic [31:0] RD = 32'hA5A5A5A5;
    localparam int NV = 15;

    ins_t  vin [NV];
    outs_t vex [NV];

    initial begin
        //             if_req ifaddr   dm_req we  dm_addr  dm_wdata       mem_out
        vin[0]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,         32'h0};
        vin[1]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h00, 32'h0,         IR};
        vin[2]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,         IR};
        vin[3]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,         32'h0};
        vin[4]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF,  32'h12345678};
        vin[5]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,         32'h12345678};
        vin[6]  = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h22, 32'h0,         32'hFFFFFFFF};
        vin[7]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,         32'hFFFFFFFF};
        vin[8]  = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h24, 32'h0BADF00D,  RD};
        vin[9]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,         RD};
        vin[10] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,         32'h0};
        vin[11] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,         32'h0};
        vin[12] = '{1'b1, 32'h13, 1'b0, 1'b0, 32'h00, 32'h0,         32'h77777777};
        vin[13] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,         32'h77777777};
        vin[14] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0,         32'h0};
        //            ifrdy dmrdy ifrv  if_rdata if_err dmrv  dm_rdata dm_err mem_pc  mem_in        wmem  busy
        vex[0]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0};
        vex[1]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0};
        vex[2]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h10, 32'h0,        1'b0, 1'b1};
        vex[3]  = '{1'b0, 1'b0, 1'b1, IR,    1'b0, 1'b0, 32'h0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0};
        vex[4]  = '{1'b0, 1'b1, 1'b0, IR,    1'b0, 1'b0, 32'h0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0};
        vex[5]  = '{1'b0, 1'b0, 1'b0, IR,    1'b0, 1'b0, 32'h0, 1'b0, 32'h20, 32'hDEADBEEF, 1'b1, 1'b1};
        vex[6]  = '{1'b0, 1'b1, 1'b0, IR,    1'b0, 1'b1, 32'h0, 1'b0, 32'h00, 32'h0,        1'b0, 1'b0};
        vex[7]  = '{1'b0, 1'b0, 1'b0, IR,    1'b0, 1'b1, 32'h0, 1'b1, 32'h00, 32'h0,        1'b0, 1'b0};
        vex[8]  = '{1'b0, 1'b1, 1'b0, IR,    1'b0, 1'b0, 32'h0, 1'b1, 32'h00, 32'h0,        1'b0, 1'b0};
        vex[9]  = '{1'b0, 1'b0, 1'b0, IR,    1'b0, 1'b0, 32'h0, 1'b1, 32'h24, 32'h0BADF00D, 1'b0, 1'b1};
        vex[10] = '{1'b0, 1'b0, 1'b0, IR,    1'b0, 1'b1, RD,    1'b0, 32'h00, 32'h0,        1'b0, 1'b0};
        vex[11] = '{1'b0, 1'b0, 1'b0, IR,    1'b0, 1'b0, RD,    1'b0, 32'h00, 32'h0,        1'b0, 1'b0};
        vex[12] = '{1'b1, 1'b0, 1'b0, IR,    1'b0, 1'b0, RD,    1'b0, 32'h00, 32'h0,        1'b0, 1'b0};
        vex[13] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, RD,    1'b0, 32'h00, 32'h0,        1'b0, 1'b0};
        vex[14] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, RD,    1'b0, 32'h00, 32'h0,        1'b0, 1'b0};
    end

    initial begin : main
        logic [9:0]  order;
        int          ng, nb_if, nb_dm, pc5, bad;
        int          rdy[$];
        int          rv[$];
        logic [31:0] rd[$];

        zero_inputs();
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("reset_zero_a", 32'(|oa), 32'd0);
        chk("reset_zero_b", 32'(|ob), 32'd0);
        @(posedge clk); #1 resetn = 1'b1;

        // Single-cycle vectors against u_a
        for (int i = 0; i < NV; i++) begin
            {if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_out} = vin[i];
            @(negedge clk);
            checks++;
            if (oa !== vex[i]) begin
                failures++;
                $display("FAIL vec%0d: got %h expected %h", i, oa, vex[i]);
            end
            @(posedge clk); #1;
        end

        // Both requesters held high: starvation guard on u_a, strict priority on u_b
        do_reset();
        if_req = 1'b1; dm_req = 1'b1; dm_addr = 32'h40;
        order = '0; ng = 0; nb_if = 0; nb_dm = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (a_if_ready || a_dm_ready) begin
                if (ng < 10) order[ng] = a_if_ready;
                ng++;
            end
            if (b_if_ready) nb_if++;
            if (b_dm_ready) nb_dm++;
            @(posedge clk); #1;
        end
        chk("starve_order_a", 32'(order), 32'h210);
        chk("starve_grants_a", ng, 20);
        chk("strict_if_grants_b", nb_if, 0);
        chk("strict_dm_grants_b", nb_dm, 10);

        // Back-to-back fetches at MEM_LAT=3 on u_b
        do_reset();
        if_req = 1'b1; if_addr = 32'h0; mem_out = 32'h11111111; pc5 = -1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (b_if_ready) rdy.push_back(c);
            if (b_if_rvalid) begin
                rv.push_back(c);
                rd.push_back(b_if_rdata);
            end
            if (c == 5) pc5 = b_mem_pc;
            @(posedge clk); #1;
            if (rdy.size() == 1) if_addr = 32'h4;
            if (rdy.size() >= 2) if_req = 1'b0;
            if (rv.size() >= 1) mem_out = 32'h22222222;
        end
        chk("b2b_nready", rdy.size(), 2);
        chk("b2b_ready0", rdy.size() > 0 ? rdy[0] : -1, 0);
        chk("b2b_ready1", rdy.size() > 1 ? rdy[1] : -1, 4);
        chk("b2b_nrvalid", rv.size(), 2);
        chk("b2b_rvalid0", rv.size() > 0 ? rv[0] : -1, 4);
        chk("b2b_rvalid1", rv.size() > 1 ? rv[1] : -1, 8);
        chk("b2b_rdata0", rd.size() > 0 ? rd[0] : 32'hX, 32'h11111111);
        chk("b2b_rdata1", rd.size() > 1 ? rd[1] : 32'hX, 32'h22222222);
        chk("b2b_pc_second", pc5, 32'h4);

        // Reset asserted in the middle of a MEM_LAT=3 write on u_b
        do_reset();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h30; dm_wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rst_wr_ready_b", 32'(b_dm_ready), 32'd1);
        @(posedge clk); #1 dm_req = 1'b0;
        @(negedge clk);
        chk("rst_wr_busy_b", 32'(b_busy), 32'd1);
        chk("rst_wr_pc_b", b_mem_pc, 32'h30);
        #2 resetn = 1'b0;
        #1 chk("rst_async_zero_b", 32'(|ob), 32'd0);
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) resetn = 1'b1;
            @(negedge clk);
            if (b_mem_wmem || b_if_rvalid || b_dm_rvalid) bad++;
        end
        chk("rst_no_wmem_rvalid_b", bad, 0);
        @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h8;
        @(negedge clk);
        chk("rst_idle_accept_b", 32'(b_if_ready), 32'd1);
        @(posedge clk); #1 if_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
